// File: rtl/btn_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_debouncer_pkg
// Description : Shared constants, types and helpers for the button debouncer.
//               DEBOUNCE_CYCLES_DEFAULT : 20 ms stability window at 50 MHz.
//               cnt_width()             : stability counter width for a window.
//               btn_vec_t               : board-level 4-button vector.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_debouncer_pkg;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

   typedef logic [3:0] btn_vec_t;

   // Counter must hold 0 .. cycles-1.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles);
   endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_channel
// Description : One button channel: two-flop synchroniser, stability counter,
//               debounced level and registered press/release pulses.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               raw_i           - asynchronous raw button level
//               db_o            - debounced level
//               press_o         - one-cycle pulse on debounced 0->1
//               release_o       - one-cycle pulse on debounced 1->0
//               press_d_o       - next-state of press_o (for sticky flags)
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_channel
   import btn_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic db_o,
   output logic press_o,
   output logic release_o,
   output logic press_d_o
);

   localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q, s2_q;
   logic          db_q, db_d;
   logic          press_q, press_d;
   logic          rel_q, rel_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Any cycle where the synchronised level matches the accepted level
   // discards the partial count; the commit happens on the edge after the
   // counter has sat at its maximum, so the counter never wraps.
   always_comb begin
      cnt_d   = cnt_q;
      db_d    = db_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      if (s2_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d   = '0;
         db_d    = s2_q;
         press_d = s2_q;
         rel_d   = ~s2_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         cnt_q   <= '0;
         db_q    <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         s1_q    <= raw_i;
         s2_q    <= s1_q;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   assign db_o      = db_q;
   assign press_o   = press_q;
   assign release_o = rel_q;
   assign press_d_o = press_d;

endmodule
`default_nettype wire

// File: rtl/btn_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : btn_debouncer
// Description : N_BTN-channel button conditioner: synchronise, debounce and
//               edge-detect each raw button. Optional sticky press flags with
//               write-1-to-clear and an aggregate interrupt, enabled by
//               defining BTN_DEBOUNCE_STICKY_EN. Without it btn_evt/btn_irq
//               are tied low and evt_clr is ignored.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               btn_raw      - raw button levels (1 = pressed)
//               btn_db       - debounced levels
//               btn_press    - one-cycle debounced 0->1 pulses
//               btn_release  - one-cycle debounced 1->0 pulses
//               btn_evt      - sticky press flags
//               evt_clr      - write-1-to-clear for btn_evt
//               btn_irq      - OR of btn_evt
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debouncer
   import btn_debouncer_pkg::*;
#(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_db,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_evt,
   input  logic [N_BTN-1:0] evt_clr,
   output logic             btn_irq
);

   logic [N_BTN-1:0] press_d;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .raw_i     (btn_raw[i]),
         .db_o      (btn_db[i]),
         .press_o   (btn_press[i]),
         .release_o (btn_release[i]),
         .press_d_o (press_d[i])
      );
   end

`ifdef BTN_DEBOUNCE_STICKY_EN
   logic [N_BTN-1:0] evt_q, evt_d;
   logic             irq_q;

   // Set is OR-ed in after the clear, so a press on the same edge wins.
   always_comb begin
      evt_d = (evt_q & ~evt_clr) | press_d;
   end

   // IRQ is registered from the next-state flags so it moves with btn_evt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_q <= '0;
         irq_q <= 1'b0;
      end else begin
         evt_q <= evt_d;
         irq_q <= |evt_d;
      end
   end

   assign btn_evt = evt_q;
   assign btn_irq = irq_q;
`else
   logic unused_sticky;
   assign unused_sticky = ^{evt_clr, press_d};
   assign btn_evt       = '0;
   assign btn_irq       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btn_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_debouncer
// Description : Self-checking bench for btn_debouncer (DEBOUNCE_CYCLES = 4).
//               Reference model: a channel's accepted level flips on an edge
//               when the synchronised level seen over the last
//               DEBOUNCE_CYCLES edges all differed from it. Sticky-flag
//               expectations follow BTN_DEBOUNCE_STICKY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_debouncer;

   localparam int N = 4;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] btn_raw;
   logic [N-1:0] evt_clr;
   logic [N-1:0] btn_db, btn_press, btn_release, btn_evt;
   logic         btn_irq;

   btn_debouncer #(
      .N_BTN           (N),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .btn_db      (btn_db),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_evt     (btn_evt),
      .evt_clr     (evt_clr),
      .btn_irq     (btn_irq)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // hist[0] is the raw value sampled at the latest edge; the synchroniser
   // output the debounce logic sees at that edge is two samples older.
   logic [N-1:0] hist [0:D+1];
   logic [N-1:0] db_m, pr_m, rl_m, evt_m;
   logic         irq_m;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   task automatic model_reset();
      for (int j = 0; j <= D + 1; j++) hist[j] = '0;
      db_m  = '0;
      pr_m  = '0;
      rl_m  = '0;
      evt_m = '0;
      irq_m = 1'b0;
   endtask

   task automatic model_edge();
      if (rst) begin
         model_reset();
      end else begin
         for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = btn_raw;
         for (int i = 0; i < N; i++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int j = 2; j <= D + 1; j++)
               if (hist[j][i] == db_m[i]) all_diff = 1'b0;
            pr_m[i] = all_diff & ~db_m[i];
            rl_m[i] = all_diff &  db_m[i];
            if (all_diff) db_m[i] = ~db_m[i];
         end
`ifdef BTN_DEBOUNCE_STICKY_EN
         evt_m = (evt_m & ~evt_clr) | pr_m;
         irq_m = |evt_m;
`endif
      end
   endtask

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".db"},      btn_db,              db_m);
      chk({tag, ".press"},   btn_press,           pr_m);
      chk({tag, ".release"}, btn_release,         rl_m);
      chk({tag, ".evt"},     btn_evt,             evt_m);
      chk({tag, ".irq"},     {3'b000, btn_irq},   {3'b000, irq_m});
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic steps(input int n, input string tag);
      for (int k = 0; k < n; k++) step(tag);
   endtask

   initial begin
      logic [N-1:0] exp_evt;

      // ---- reset and idle ----
      rst     = 1'b1;
      btn_raw = '0;
      evt_clr = '0;
      model_reset();
      #12;
      check_all("reset");
      steps(2, "in_reset");
      rst = 1'b0;
      steps(20, "idle");

      // ---- channel 0 press and release: pulse on the 6th edge (edge 5) ----
      btn_raw = 4'h1;
      for (int k = 1; k <= 8; k++) begin
         step("ch0_rise");
         chk("ch0_press_timing", btn_press, (k == 6) ? 4'h1 : 4'h0);
      end
      btn_raw = 4'h0;
      for (int k = 1; k <= 8; k++) begin
         step("ch0_fall");
         chk("ch0_release_timing", btn_release, (k == 6) ? 4'h1 : 4'h0);
      end

      // ---- channel 1 bounce then hold ----
      for (int t = 0; t < 4; t++) begin
         btn_raw[1] = ~t[0];
         for (int k = 0; k < 2; k++) begin
            step("ch1_bounce");
            chk("ch1_bounce_quiet", btn_press | btn_release, 4'h0);
         end
      end
      btn_raw[1] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step("ch1_hold");
         chk("ch1_press_timing", btn_press, (k == 6) ? 4'h2 : 4'h0);
      end
      btn_raw = 4'h0;
      steps(8, "ch1_fall");

      // ---- all channels at once, then partial clear ----
      btn_raw = 4'hF;
      for (int k = 1; k <= 8; k++) begin
         step("all_rise");
         chk("all_press_timing", btn_press, (k == 6) ? 4'hF : 4'h0);
      end
`ifdef BTN_DEBOUNCE_STICKY_EN
      exp_evt = 4'hF;
`else
      exp_evt = 4'h0;
`endif
      chk("all_evt", btn_evt, exp_evt);
      evt_clr = 4'h5;
      step("clr5");
      evt_clr = 4'h0;
`ifdef BTN_DEBOUNCE_STICKY_EN
      exp_evt = 4'hA;
`else
      exp_evt = 4'h0;
`endif
      chk("evt_after_clr5", btn_evt, exp_evt);
      btn_raw = 4'h0;
      steps(8, "all_fall");
      evt_clr = 4'hF;
      step("clr_all");

      // ---- clear and set on the same edge: set wins ----
      evt_clr = 4'h4;
      btn_raw = 4'h4;
      for (int k = 1; k <= 8; k++) begin
         step("ch2_set_vs_clr");
`ifdef BTN_DEBOUNCE_STICKY_EN
         exp_evt = (k == 6) ? 4'h4 : 4'h0;
`else
         exp_evt = 4'h0;
`endif
         chk("ch2_set_wins", btn_evt, exp_evt);
      end
      evt_clr = 4'h0;
      btn_raw = 4'h0;
      steps(8, "ch2_fall");
      evt_clr = 4'hF;
      step("clr_all2");
      evt_clr = 4'h0;

      // ---- asynchronous reset mid-count with channel 3 held ----
      btn_raw = 4'h8;
      steps(5, "ch3_count");
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("rst_async");
      steps(2, "rst_hold");
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step("rst_release");
         chk("rst_press_timing", btn_press, (k == 6) ? 4'h8 : 4'h0);
      end

      // ---- randomized levels, hold lengths and clears ----
      for (int seg = 0; seg < 60; seg++) begin
         int hold;
         btn_raw = 4'($urandom);
         hold    = $urandom_range(1, 8);
         for (int k = 0; k < hold; k++) begin
            evt_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step("random");
         end
      end
      evt_clr = 4'h0;
      steps(10, "random_tail");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
